// File: rtl/syn_counter_pkg.sv
// Shared constants and types for the synchronous modulo-N up/down counter.
// The default configuration is a single BCD digit.
package syn_counter_pkg;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_MODULUS = 10;

  typedef logic [DEFAULT_WIDTH-1:0] cnt_t;

  // Per-edge operation, listed in priority order.
  typedef enum logic [1:0] {
    OP_RESET,
    OP_LOAD,
    OP_COUNT,
    OP_HOLD
  } op_e;

endpackage

// File: rtl/cnt_next_state.sv
// Combinational next-state logic for the up/down counter: next count, terminal count,
// and the out-of-range load condition. It holds no state; the top owns the registers.
module cnt_next_state
  import syn_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  output logic [WIDTH-1:0] q_next,
  output logic             tc,
  output logic             load_err_next
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  op_e op;

  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (en) begin
      op = OP_COUNT;
    end
  end

  // Wrap is decided by comparing against the terminal value, not by natural
  // overflow, so a modulus below 2**WIDTH still wraps at the right place.
  always_comb begin
    q_next        = q;
    load_err_next = 1'b0;
    case (op)
      OP_LOAD: begin
        if (d > MAX_VAL) begin
          q_next        = MAX_VAL;
          load_err_next = 1'b1;
        end else begin
          q_next = d;
        end
      end
      OP_COUNT: begin
        if (up) begin
          q_next = (q == MAX_VAL) ? '0 : q + WIDTH'(1);
        end else begin
          q_next = (q == '0) ? MAX_VAL : q - WIDTH'(1);
        end
      end
      default: begin
        q_next        = q;
        load_err_next = 1'b0;
      end
    endcase
  end

  // Depends on the current count only, so on a simultaneous load it reflects the pre-load value.
  assign tc = en & ((up & (q == MAX_VAL)) | (~up & (q == '0)));

endmodule

// File: rtl/syn_updown_counter.sv
// Synchronous modulo-N up/down counter with parallel load, cascade terminal count,
// and a one-cycle load-error flag. Every flop is clocked from CLK; reset is synchronous.
module syn_updown_counter
  import syn_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             LOAD_ERR
);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("syn_updown_counter: MODULUS out of range for WIDTH");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             load_err_q;
  logic             load_err_d;

  cnt_next_state #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_next (
    .q            (q_q),
    .d            (D),
    .en           (EN),
    .up           (UP),
    .load         (LOAD),
    .q_next       (q_d),
    .tc           (TC),
    .load_err_next(load_err_d)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      q_q        <= '0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      load_err_q <= load_err_d;
    end
  end

  assign Q        = q_q;
  assign LOAD_ERR = load_err_q;

  a_q_in_range : assert property (@(posedge CLK) disable iff (!RST_N)
    q_q <= WIDTH'(MODULUS - 1));

endmodule

// File: tb/tb_syn_updown_counter.sv
// Bench for syn_updown_counter: directed vectors with literal expectations, plus an
// arithmetic reference model compared against the DUT on every falling edge.
module tb_syn_updown_counter;

  localparam int W = 4;
  localparam int M = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         en    = 1'b1;
  logic         up    = 1'b1;
  logic         load  = 1'b1;
  logic [W-1:0] d     = 4'd5;
  logic [W-1:0] q;
  logic         tc;
  logic         load_err;

  // cascade pair: stage 1 counts on stage 0 terminal count
  logic         cas_rst_n = 1'b0;
  logic         cas_en    = 1'b0;
  logic         cas_up    = 1'b1;
  logic         cas_load  = 1'b0;
  logic [W-1:0] cas_d     = '0;
  logic [W-1:0] q0, q1;
  logic         tc0, tc1, err0, err1;

  syn_updown_counter #(.WIDTH(W), .MODULUS(M)) u_dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .UP(up), .LOAD(load), .D(d),
    .Q(q), .TC(tc), .LOAD_ERR(load_err)
  );

  syn_updown_counter #(.WIDTH(W), .MODULUS(M)) u_cas0 (
    .CLK(clk), .RST_N(cas_rst_n), .EN(cas_en), .UP(cas_up), .LOAD(cas_load), .D(cas_d),
    .Q(q0), .TC(tc0), .LOAD_ERR(err0)
  );

  syn_updown_counter #(.WIDTH(W), .MODULUS(M)) u_cas1 (
    .CLK(clk), .RST_N(cas_rst_n), .EN(tc0), .UP(cas_up), .LOAD(cas_load), .D(cas_d),
    .Q(q1), .TC(tc1), .LOAD_ERR(err1)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_q = 0, m_err = 0;
  bit m_valid = 0;
  int c_n = 0;           // cascade pair viewed as one mod-100 count
  bit c_valid = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q = 0; m_err = 0; m_valid = 1;
    end else if (m_valid) begin
      if (load) begin
        if (int'(d) >= M) begin m_q = M - 1; m_err = 1; end
        else begin m_q = int'(d); m_err = 0; end
      end else begin
        m_err = 0;
        if (en) m_q = up ? (m_q + 1) % M : (m_q + M - 1) % M;
      end
    end
    if (!cas_rst_n) begin
      c_n = 0; c_valid = 1;
    end else if (c_valid && cas_en) begin
      c_n = (c_n + 1) % (M * M);
    end
  end

  function automatic int model_tc(int mq, bit men, bit mup);
    return (men && ((mup && mq == M - 1) || (!mup && mq == 0))) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_q", int'(q), m_q);
      check("model_load_err", int'(load_err), m_err);
      check("model_tc", int'(tc), model_tc(m_q, en, up));
    end
    if (c_valid) begin
      check("cas_q0", int'(q0), c_n % M);
      check("cas_q1", int'(q1), c_n / M);
      check("cas_tc0", int'(tc0), model_tc(c_n % M, cas_en, 1'b1));
      check("cas_tc1", int'(tc1), model_tc(c_n / M, tc0, 1'b1));
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int seq_up [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int seq_dn [5]  = '{2, 1, 0, 9, 8};

    // 1: reset overrides load and enable
    step(); step();
    check("rst_q", int'(q), 0);
    check("rst_load_err", int'(load_err), 0);
    check("rst_tc", int'(tc), 0);

    // 2: count up through the wrap
    rst_n = 1'b1; load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("up_seq_q", int'(q), seq_up[i]);
      check("up_seq_tc", int'(tc), (seq_up[i] == 9) ? 1 : 0);
    end

    // 3: load 3, count down through the wrap
    load = 1'b1; d = 4'd3; up = 1'b0;
    step();
    check("load3_q", int'(q), 3);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("dn_seq_q", int'(q), seq_dn[i]);
      check("dn_seq_tc", int'(tc), (seq_dn[i] == 0) ? 1 : 0);
    end

    // 4: out-of-range load clamps and flags for one cycle
    load = 1'b1; d = 4'd12;
    step();
    check("bad_load_q", int'(q), 9);
    check("bad_load_err", int'(load_err), 1);
    load = 1'b0; en = 1'b0;
    step();
    check("bad_load_err_clear", int'(load_err), 0);
    check("hold_q", int'(q), 9);
    // boundary: D = MODULUS is an error, D = MODULUS-1 is not
    load = 1'b1; d = 4'd10;
    step();
    check("load10_err", int'(load_err), 1);
    d = 4'd9;
    step();
    check("load9_err", int'(load_err), 0);
    check("load9_q", int'(q), 9);

    // 5: load wins over count; TC reflects pre-load Q
    d = 4'd4; load = 1'b1;
    step();
    up = 1'b1; en = 1'b1; load = 1'b1; d = 4'd7;
    step();
    check("load_priority_q", int'(q), 7);
    d = 4'd9;
    step();
    d = 4'd7;
    #1;
    check("preload_tc", int'(tc), 1);
    step();
    check("preload_after_q", int'(q), 7);

    // reset mid-count, then resume from 0
    load = 1'b0; rst_n = 1'b0;
    step();
    check("midrst_q", int'(q), 0);
    rst_n = 1'b1;
    step();
    check("resume_q", int'(q), 1);

    // direction change on the same edge
    up = 1'b0;
    step();
    check("dir_change_q", int'(q), 0);

    // 6: cascade, 100 edges from 0
    cas_rst_n = 1'b0;
    step();
    cas_rst_n = 1'b1; cas_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 99) begin
        check("cas99_tc0", int'(tc0), 1);
        check("cas99_tc1", int'(tc1), 1);
        check("cas99_q", int'({q1, q0}), 8'h99);
      end
      step();
    end
    check("cas_end_q0", int'(q0), 0);
    check("cas_end_q1", int'(q1), 0);
    cas_en = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/syn_updown_counter.md
Name: syn_updown_counter

Overview:
- Synchronous modulo-N up/down counter built from D flip-flops with enable and a common clock. There is no ripple clocking.
- Serves as the counting end of the storage-element work in the syn_counter area: the flip-flops store state, and this block sequences it.
- Provides parallel load, direction control, a terminal-count output for cascading, and a load-error flag.
- Default configuration is a BCD digit (0..9).

Parameters:
WIDTH, 4, counter register width in bits
MODULUS, 10, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH

Ports:
CLK  input  1  single clock; all state updates on posedge CLK
RST_N  input  1  synchronous active-low reset, sampled on posedge CLK
EN  input  1  count enable (cascade input; tie to previous stage TC)
UP  input  1  direction: 1 = increment, 0 = decrement
LOAD  input  1  synchronous parallel load request
D  input  WIDTH  parallel load value
Q  output  WIDTH  current count (registered)
TC  output  1  terminal count, combinational: EN & ((UP & Q==MODULUS-1) | (!UP & Q==0))
LOAD_ERR  output  1  registered; high for exactly one cycle after an out-of-range load

Behaviour:
- Reset: RST_N is only sampled at posedge CLK; there is no asynchronous path. When RST_N=0 at posedge CLK: Q=0, LOAD_ERR=0. Reset overrides LOAD and EN in the same cycle.
- Priority per edge: RST_N low > LOAD > EN > hold.
- LOAD=1 with D<=MODULUS-1: Q<=D, LOAD_ERR<=0. EN is ignored that cycle.
- LOAD=1 with D>=MODULUS: Q<=MODULUS-1 (clamp), LOAD_ERR<=1 for the next cycle only.
- EN=1, LOAD=0, UP=1: Q<=Q+1, wrapping MODULUS-1 -> 0.
- EN=1, LOAD=0, UP=0: Q<=Q-1, wrapping 0 -> MODULUS-1.
- EN=0, LOAD=0: Q holds. LOAD_ERR<=0 in every cycle without an erroneous load.
- Latency: one clock from the request edge to the new Q. TC follows Q, EN and UP combinationally with no register delay.
- Arithmetic is done in WIDTH bits; the wrap is decided by comparing Q with the terminal value, never by natural overflow. This keeps MODULUS < 2**WIDTH correct. When MODULUS==2**WIDTH, the comparison and natural wrap coincide.
- Direction change takes effect on the same edge it is sampled; there is no turnaround cycle.
- Simultaneous LOAD and EN: load wins and TC still reflects the pre-load Q. A cascaded next stage may therefore count on that edge; this is documented, intended behaviour.
- Reset released mid-count: counting resumes from 0 on the first edge with RST_N=1 and EN=1.
- Q never leaves 0..MODULUS-1 after reset. An assertion covers this.
- No latches: every output register is assigned on every branch of the clocked process.

Decomposition:
- Package syn_counter_pkg holds:
  - counter state typedef (logic [WIDTH-1:0] via a parameterised width constant);
  - DEFAULT_WIDTH=4 and DEFAULT_MODULUS=10 constants;
  - priority encoding enum {OP_RESET, OP_LOAD, OP_COUNT, OP_HOLD}.
- One sub-module, cnt_next_state:
  - purely combinational; computes next Q, TC and the load-error condition from Q, D, EN, UP, LOAD;
  - the top instantiates it and owns only the registers.

Test Plan:
1. RST_N=0 for 2 edges with EN=1, LOAD=1, D=5 -> Q=0, LOAD_ERR=0, TC=0 while UP=1.
2. Reset, then UP=1, EN=1 for 12 edges -> Q sequence 1..9,0,1,2; TC=1 only while Q=9.
3. LOAD=1, D=3, then UP=0, EN=1 for 5 edges -> Q=3,2,1,0,9,8; TC=1 while Q=0.
4. LOAD=1, D=12 (MODULUS=10) -> Q=9 next edge, LOAD_ERR=1 for exactly one cycle, then 0.
5. Q=4, UP=1, EN=1, LOAD=1, D=7 on the same edge -> Q=7 (load priority). With Q=9 and the same inputs, TC=1 before the edge.
6. Two instances cascaded (stage1 EN = stage0 TC), UP=1, 100 edges from 0 -> {Q1,Q0} = 0,0 with both TC pulses aligned at 99.
